// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller with double-buffered characters
// and a blanking gap before each digit lights.
module display_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  output logic [3:0] char_sel,
  output logic [3:0] anodes,
  output logic [1:0] digit_idx,
  output logic       frame_done,
  output logic       commit_pending
);

  localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      idx_nxt;
  logic [3:0]      char_q, char_d;
  logic [3:0]      an_q, an_d;
  logic            fd_q, fd_d;
  logic            pend_q, pend_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic [3:0][3:0] ac_q, ac_d;
  logic            boundary;
  logic            copy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    char_d   = char_q;
    an_d     = an_q;
    sh_d     = sh_q;
    ac_d     = ac_q;
    pend_d   = pend_q;
    idx_nxt  = idx_q + 2'd1;
    boundary = (state_q == SHOW) && (idx_q == 2'd3) &&
               (cnt_q == SHOW_LAST) && en;
    copy     = boundary && (pend_q || commit);

    // copy sees pre-edge shadow; a same-cycle write waits for next commit
    if (copy) begin
      ac_d   = sh_q;
      pend_d = 1'b0;
    end else if (commit) begin
      pend_d = 1'b1;
    end
    if (wr_en) sh_d[wr_addr] = wr_data;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = 2'd0;
          char_d  = ac_q[0];
          an_d    = 4'hF;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
          char_d  = 4'h0;
          an_d    = 4'hF;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          an_d    = ~(4'b0001 << idx_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
          char_d  = 4'h0;
          an_d    = 4'hF;
        end else if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_nxt;
          char_d  = ac_d[idx_nxt];
          an_d    = 4'hF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = 2'd0;
        char_d  = 4'h0;
        an_d    = 4'hF;
      end
    endcase

    // registered pulse: high exactly during the last digit-3 SHOW cycle
    fd_d = (state_d == SHOW) && (idx_d == 2'd3) && (cnt_d == SHOW_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      char_q  <= 4'h0;
      an_q    <= 4'hF;
      fd_q    <= 1'b0;
      pend_q  <= 1'b0;
      sh_q    <= '0;
      ac_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
      pend_q  <= pend_d;
      sh_q    <= sh_d;
      ac_q    <= ac_d;
    end
  end

  assign char_sel       = char_q;
  assign anodes         = an_q;
  assign digit_idx      = idx_q;
  assign frame_done     = fd_q;
  assign commit_pending = pend_q;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display, sitting directly upstream of `DisplayDecoder`. Its `char_sel` output feeds the decoder's `char_sel` input, and its `anodes` output drives the digit enables. It keeps a double-buffered set of four 4-bit characters, so the CPU/bus side can update the display without tearing. It inserts a blanking interval before each digit to suppress ghosting.

## Interface

Parameters:
- `CLK_DIV`, default 50000: cycles each digit is lit (SHOW). Legal range is 1 or more.
- `BLANK_CYCLES`, default 1000: cycles all anodes stay off before each digit (BLANK). Legal range is 1 or more.

Ports:
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable. Low forces IDLE.
- `wr_en`  in  1  write strobe into the shadow buffer.
- `wr_addr`  in  2  shadow digit index, 0 to 3.
- `wr_data`  in  4  character code.
- `commit`  in  1  request to copy shadow to active at the next frame boundary.
- `char_sel`  out  4  character to `DisplayDecoder`. Registered.
- `anodes`  out  4  digit enables, active-low. Registered. Bit i selects digit i.
- `digit_idx`  out  2  digit currently being scanned.
- `frame_done`  out  1  one-cycle pulse at the end of each digit-3 SHOW.
- `commit_pending`  out  1  a commit is requested but not yet applied.

## Operation

- Storage:
  - `shadow[0..3]` and `active[0..3]`, each 4 bits.
  - Both reset to 0.
- Writes:
  - `wr_en` writes `shadow[wr_addr] <= wr_data` in any state.
  - `active` changes only at a frame boundary.
- States: IDLE, BLANK, SHOW.
  - Reset enters IDLE.
- IDLE:
  - `anodes`=4'hF, `char_sel`=0, `digit_idx`=0.
  - When `en`=1, go to BLANK for digit 0 on the next edge.
- BLANK:
  - Lasts exactly `BLANK_CYCLES` cycles.
  - `anodes`=4'hF and `char_sel`=`active[digit_idx]`, so the decoder settles before the digit lights.
  - Then go to SHOW.
- SHOW:
  - Lasts exactly `CLK_DIV` cycles.
  - `anodes` = all ones except bit `digit_idx`=0. `char_sel` is held.
  - At the end, `digit_idx` increments modulo 4 and the state returns to BLANK.
- Frame boundary (last cycle of SHOW with `digit_idx`=3):
  - `frame_done`=1 for that one cycle.
  - If `commit_pending`=1 or `commit`=1 in that cycle, then `active <= shadow` on that edge and `commit_pending` clears.
  - The following BLANK for digit 0 therefore shows the new data.
- Commit handling:
  - `commit` asserted outside a boundary cycle sets `commit_pending` on the next edge.
  - Repeated commits are idempotent.
- Write and copy in the same cycle:
  - The copy uses the pre-edge `shadow` value.
  - The write lands in `shadow` only and is shown after the next commit.
- `en` deasserted in BLANK or SHOW:
  - Next edge goes to IDLE with `anodes`=4'hF and `digit_idx`=0. The cycle counter clears.
  - `active`, `shadow` and `commit_pending` are preserved.
  - No copy happens while in IDLE.
- Reset in any state:
  - All state returns to reset values on the next edge.
  - Any pending commit is lost.
- Cycle counter:
  - Width is `$clog2(max(CLK_DIV, BLANK_CYCLES))`, minimum 1.
  - Clears on every state entry.

## Timing

- Output reset values: `char_sel`=0, `anodes`=4'hF, `digit_idx`=0, `frame_done`=0, `commit_pending`=0.
- `rst` released with `en`=1 held: the first edge after release enters BLANK (digit 0), and `char_sel`=`active[0]` from that edge.
- Digit slot is `BLANK_CYCLES`+`CLK_DIV` cycles. Frame is 4×(`BLANK_CYCLES`+`CLK_DIV`) cycles.
- `frame_done` period equals the frame length while `en`=1.
- `anodes` never has more than one bit low. Any change of `char_sel` happens only while `anodes`=4'hF.
- Commit latency: from the edge after `commit` to the frame boundary. Worst case is one frame. The new data reaches `char_sel` on the edge closing the boundary cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

Bench parameters: `CLK_DIV`=4, `BLANK_CYCLES`=2 (frame = 24 cycles).

1. Reset and scan with no writes. Hold `rst` high, then release it with `en`=1.
   - `anodes` follows 4'hF ×2, 4'hE ×4, 4'hF ×2, 4'hD ×4, 4'hF ×2, 4'hB ×4, 4'hF ×2, 4'h7 ×4, then repeats.
   - `char_sel`=0 throughout.
   - `frame_done` pulses every 24 cycles, during the last 4'h7 cycle.
2. Double buffering. Write digits 0 to 3 with 1, 2, 3, 4 mid-frame and pulse `commit` once.
   - `commit_pending`=1 on the next edge.
   - `char_sel` stays 0 until the boundary, then reads 1, 2, 3, 4 in successive slots.
   - `commit_pending`=0 after the boundary.
3. Commit in the boundary cycle. Assert `commit` and `wr_en` (addr 0, data 9) only in the `frame_done` cycle, with shadow holding 5, 6, 7, 8.
   - `active` becomes 5, 6, 7, 8. The 9 is not shown.
   - A second commit shows 9 on digit 0 one frame later.
4. `en` dropped during SHOW of digit 2.
   - The next edge gives `anodes`=4'hF and `digit_idx`=0.
   - Re-raising `en` restarts at BLANK of digit 0 with unchanged `active`.
5. Reset mid-operation with a commit pending.
   - All outputs return to reset values, with `commit_pending`=0 and `char_sel`=0.
6. One-hot check. Run 10 frames with random writes and commits.
   - `anodes` is never other than 4'hF or a single zero bit.
   - `char_sel` never changes while any anode is low.
